// File: rtl/matmul_pkg.sv
// Shared types and arithmetic helpers for the K-streaming matmul accumulator.
package matmul_pkg;

  localparam int ACC_W = 32;

  typedef enum logic [1:0] {
    PREC_8x8 = 2'b00,
    PREC_8x4 = 2'b01,
    PREC_4x4 = 2'b10
  } prec_mode_e;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} kacc_state_e;

  typedef struct packed {
    logic [ACC_W-1:0] val;
    logic             ovf;
  } acc_res_t;

  // 4-bit two's complement nibble to 8-bit signed
  function automatic logic signed [7:0] sext4(input logic [3:0] n);
    return {{4{n[3]}}, n};
  endfunction

  // The reserved encoding 2'b11 behaves as int8 x int8
  function automatic prec_mode_e decode_mode(input logic [1:0] m);
    return (m == 2'b11) ? PREC_8x8 : prec_mode_e'(m);
  endfunction

  // Exact add at 65 bits, then clamp (sat) or wrap to int32; ovf flags out-of-range
  function automatic acc_res_t sat_add32(input logic signed [ACC_W-1:0] acc,
                                         input logic signed [63:0]      psum,
                                         input logic                    sat);
    logic signed [64:0] s;
    logic signed [64:0] vmax;
    logic signed [64:0] vmin;
    acc_res_t           r;
    vmax  = 65'sd2147483647;
    vmin  = -vmax - 65'sd1;
    s     = 65'(acc) + 65'(psum);
    r.ovf = (s > vmax) || (s < vmin);
    if (r.ovf && sat) r.val = s[64] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else              r.val = s[ACC_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/mixed_precision_dot.sv
// Combinational KT-lane dot product for one output element, precision selected by mode.
module mixed_precision_dot
  import matmul_pkg::*;
#(
  parameter int KT   = 2,
  parameter int PS_W = 34
) (
  input  logic [KT-1:0][7:0]     i_a,
  input  logic [KT-1:0][7:0]     i_b,
  input  prec_mode_e             i_mode,
  output logic signed [PS_W-1:0] o_psum
);

  logic signed [PS_W-1:0] w_sum;

  // Sum the KT lane products; packed int4 contributes two products per lane
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < KT; k++) begin
      case (i_mode)
        PREC_8x4: w_sum = w_sum + PS_W'($signed(i_a[k])) * PS_W'(sext4(i_b[k][3:0]));
        PREC_4x4: w_sum = w_sum
                        + PS_W'(sext4(i_a[k][7:4])) * PS_W'(sext4(i_b[k][7:4]))
                        + PS_W'(sext4(i_a[k][3:0])) * PS_W'(sext4(i_b[k][3:0]));
        default:  w_sum = w_sum + PS_W'($signed(i_a[k])) * PS_W'($signed(i_b[k]));
      endcase
    end
  end

  assign o_psum = w_sum;

endmodule

// File: rtl/matmul_kstream_accumulator.sv
// D = C + sum over streamed K-tiles of A_b x B_b, with optional product register stage.
module matmul_kstream_accumulator
  import matmul_pkg::*;
#(
  parameter int M     = 2,
  parameter int N     = 2,
  parameter int KT    = 2,
  parameter int P     = 8,
  parameter int PIPE  = 1,
  parameter int SAT   = 0,
  parameter int CNT_W = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [M-1:0][KT-1:0][P-1:0]       A_i,
  input  logic [KT-1:0][N-1:0][P-1:0]       B_i,
  input  logic [M-1:0][N-1:0][ACC_W-1:0]    C_i,
  input  logic [1:0]                        mode_i,
  input  logic                              first_i,
  input  logic                              last_i,
  input  logic                              valid_in,
  output logic                              ready_in,
  output logic [M-1:0][N-1:0][ACC_W-1:0]    D_o,
  output logic                              valid_out,
  input  logic                              ready_out,
  output logic                              ovf_o,
  output logic                              protocol_err_o,
  output logic [CNT_W-1:0]                  beat_cnt_o
);

  localparam int PS_W = ACC_W + $clog2(2*KT);
  localparam bit PIPED = (PIPE != 0);

  kacc_state_e                        r_state, w_next;
  prec_mode_e                         r_mode, w_mode;
  logic                               w_accept, w_start, w_add, w_busy, w_new_ovf;
  logic [PIPE:0]                      w_vld_pipe;
  logic [N-1:0][KT-1:0][P-1:0]        w_bcol;
  logic [M-1:0][N-1:0][PS_W-1:0]      w_psum, w_psum_s;
  logic [M-1:0][N-1:0][ACC_W-1:0]     r_acc;
  acc_res_t                           w_res [M][N];
  logic                               r_ovf, r_perr;
  logic [CNT_W-1:0]                   r_cnt;

  assign w_accept      = valid_in & ready_in;
  // Any beat taken in IDLE opens a group; first_i in ACCUM restarts it
  assign w_start       = w_accept & ((r_state == IDLE) | first_i);
  assign w_mode        = w_start ? decode_mode(mode_i) : r_mode;
  assign w_vld_pipe[0] = w_accept;

  // Per-element dot products; B is regrouped by column
  for (genvar j = 0; j < N; j++) begin : g_col
    for (genvar k = 0; k < KT; k++) begin : g_k
      assign w_bcol[j][k] = B_i[k][j];
    end
  end
  for (genvar i = 0; i < M; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_el
      mixed_precision_dot #(.KT(KT), .PS_W(PS_W)) u_dot (
        .i_a   (A_i[i]),
        .i_b   (w_bcol[j]),
        .i_mode(w_mode),
        .o_psum(w_psum[i][j])
      );
    end
  end

  if (PIPED) begin : g_pipe
    logic                          r_vld;
    logic [M-1:0][N-1:0][PS_W-1:0] r_psum;
    // Product register stage; reset discards anything in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_vld  <= 1'b0;
        r_psum <= '0;
      end else begin
        r_vld  <= w_accept;
        r_psum <= w_psum;
      end
    end
    assign w_vld_pipe[PIPE] = r_vld;
    assign w_psum_s         = r_psum;
    assign w_busy           = r_vld;
  end else begin : g_nopipe
    assign w_psum_s = w_psum;
    assign w_busy   = 1'b0;
  end

  // A restart drops the old group's product still in the stage
  assign w_add = w_vld_pipe[PIPE] & (~PIPED | ~w_start);

  // Accumulate candidate per element, base is C on an unregistered group start
  always_comb begin
    w_new_ovf = 1'b0;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        w_res[i][j] = sat_add32(w_start ? C_i[i][j] : r_acc[i][j],
                                64'($signed(w_psum_s[i][j])), SAT != 0);
        w_new_ovf   = w_new_ovf | w_res[i][j].ovf;
      end
    end
  end

  // Accumulators, sticky overflow, latched mode, beat counter, error pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_acc  <= '0;
      r_ovf  <= 1'b0;
      r_mode <= PREC_8x8;
      r_cnt  <= '0;
      r_perr <= 1'b0;
    end else begin
      if (w_add) begin
        for (int i = 0; i < M; i++)
          for (int j = 0; j < N; j++)
            r_acc[i][j] <= w_res[i][j].val;
      end else if (w_start) begin
        r_acc <= C_i;
      end
      if (w_start)    r_ovf <= w_add & w_new_ovf;
      else if (w_add) r_ovf <= r_ovf | w_new_ovf;
      if (w_start) r_mode <= decode_mode(mode_i);
      if (w_start)                  r_cnt <= CNT_W'(1);
      else if (w_accept && ~&r_cnt) r_cnt <= r_cnt + CNT_W'(1);
      r_perr <= w_accept & (r_state == ACCUM) & first_i;
    end
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = last_i ? DRAIN : ACCUM;
      ACCUM:   if (w_accept && last_i) w_next = DRAIN;
      DRAIN:   if (!w_busy) w_next = OUT;
      OUT:     if (ready_out) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    ready_in  = (r_state == IDLE) | (r_state == ACCUM);
    valid_out = (r_state == OUT);
  end

  assign D_o            = r_acc;
  assign ovf_o          = r_ovf;
  assign protocol_err_o = r_perr;
  assign beat_cnt_o     = r_cnt;

endmodule

// File: tb/tb_matmul_kstream_accumulator.sv
// Directed bench: a wrapping and a saturating instance share one input stream.
module tb_matmul_kstream_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0][1:0][7:0]  A, B;
  logic [1:0][1:0][31:0] C;
  logic [1:0]            mode;
  logic                  first, last, vin, rout;
  logic                  rdy, vout, ovf, perr;
  logic                  rdy_s, vout_s, ovf_s, perr_s;
  logic [1:0][1:0][31:0] D, D_s;
  logic [15:0]           cnt, cnt_s;

  int n_tests = 0;
  int n_fail  = 0;

  matmul_kstream_accumulator #(.SAT(0)) u_wrap (
    .clk_i(clk), .rst_i(rst), .A_i(A), .B_i(B), .C_i(C), .mode_i(mode),
    .first_i(first), .last_i(last), .valid_in(vin), .ready_in(rdy),
    .D_o(D), .valid_out(vout), .ready_out(rout), .ovf_o(ovf),
    .protocol_err_o(perr), .beat_cnt_o(cnt)
  );

  matmul_kstream_accumulator #(.SAT(1)) u_sat (
    .clk_i(clk), .rst_i(rst), .A_i(A), .B_i(B), .C_i(C), .mode_i(mode),
    .first_i(first), .last_i(last), .valid_in(vin), .ready_in(rdy_s),
    .D_o(D_s), .valid_out(vout_s), .ready_out(rout), .ovf_o(ovf_s),
    .protocol_err_o(perr_s), .beat_cnt_o(cnt_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // A[i][k] row-major, B[k][j] row-major, every C element = c
  task automatic fill(input logic [7:0] a00, a01, a10, a11,
                      input logic [7:0] b00, b01, b10, b11, input logic [31:0] c);
    A[0][0] = a00; A[0][1] = a01; A[1][0] = a10; A[1][1] = a11;
    B[0][0] = b00; B[0][1] = b01; B[1][0] = b10; B[1][1] = b11;
    for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) C[i][j] = c;
  endtask

  // One beat; the block must already be ready. Returns 1 time unit after the accept edge.
  task automatic beat(input string tag, input logic f, input logic l, input logic [1:0] m);
    first = f; last = l; mode = m; vin = 1'b1;
    @(negedge clk);
    chk({tag, "_ready_in"}, rdy, 1'b1);
    @(posedge clk); #1;
    vin = 1'b0; first = 1'b0; last = 1'b0;
  endtask

  // Bounded wait for valid_out, then check latency, ready_in low, D, ovf, count
  task automatic expect_d(input string tag, input int lat,
                          input logic [31:0] e00, e01, e10, e11,
                          input logic eovf, input int ecnt);
    int l, rhi;
    l = 0; rhi = 0;
    while (l < 20) begin
      @(posedge clk); #1;
      l++;
      if (rdy) rhi++;
      if (vout) break;
    end
    chk({tag, "_latency"}, l, lat);
    chk({tag, "_ready_low"}, rhi, 0);
    chk({tag, "_d00"}, D[0][0], e00);
    chk({tag, "_d01"}, D[0][1], e01);
    chk({tag, "_d10"}, D[1][0], e10);
    chk({tag, "_d11"}, D[1][1], e11);
    chk({tag, "_ovf"}, ovf, eovf);
    chk({tag, "_cnt"}, cnt, ecnt);
  endtask

  task automatic handshake(input string tag);
    rout = 1'b1;
    @(posedge clk); #1;
    rout = 1'b0;
    chk({tag, "_hs_ready_in"}, rdy, 1'b1);
    chk({tag, "_hs_valid_out"}, vout, 1'b0);
  endtask

  initial begin
    A = '0; B = '0; C = '0; mode = 2'b00;
    first = 1'b0; last = 1'b0; vin = 1'b0; rout = 1'b0;

    // Reset state
    #12;
    chk("rst_valid_out", vout, 1'b0);
    chk("rst_d", D[0][0] | D[0][1] | D[1][0] | D[1][1], 32'd0);
    chk("rst_cnt", cnt, 32'd0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_perr", perr, 1'b0);
    @(posedge clk); #1; rst = 1'b0;
    chk("rst_ready_in", rdy, 1'b1);

    // 1: int8 single beat
    fill(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 32'd0);
    beat("t1", 1'b1, 1'b1, 2'b00);
    expect_d("t1", 2, 32'd19, 32'd22, 32'd43, 32'd50, 1'b0, 1);
    handshake("t1");

    // 2: three-beat group, identity x ones, C = 10
    fill(8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 32'd10);
    beat("t2a", 1'b1, 1'b0, 2'b00);
    beat("t2b", 1'b0, 1'b0, 2'b00);
    beat("t2c", 1'b0, 1'b1, 2'b00);
    expect_d("t2", 2, 32'd13, 32'd13, 32'd13, 32'd13, 1'b0, 3);
    handshake("t2");

    // 3: packed int4, then int8 and reserved mode on the same bytes
    fill(8'hF1, 8'hF1, 8'hF1, 8'hF1, 8'h23, 8'h23, 8'h23, 8'h23, 32'd0);
    beat("t3a", 1'b1, 1'b1, 2'b10);
    expect_d("t3a", 2, 32'd2, 32'd2, 32'd2, 32'd2, 1'b0, 1);
    handshake("t3a");
    beat("t3b", 1'b1, 1'b1, 2'b00);
    expect_d("t3b", 2, -32'sd1050, -32'sd1050, -32'sd1050, -32'sd1050, 1'b0, 1);
    handshake("t3b");
    beat("t3c", 1'b1, 1'b1, 2'b11);
    expect_d("t3c", 2, -32'sd1050, -32'sd1050, -32'sd1050, -32'sd1050, 1'b0, 1);
    handshake("t3c");

    // 4: int8 x int4, B high nibble ignored
    fill(8'h80, 8'h80, 8'h80, 8'h80, 8'h78, 8'h78, 8'h78, 8'h78, 32'd0);
    beat("t4", 1'b1, 1'b1, 2'b01);
    expect_d("t4", 2, 32'd2048, 32'd2048, 32'd2048, 32'd2048, 1'b0, 1);
    handshake("t4");

    // 5: overflow, wrap vs clamp; output held stable while ready_out is low
    fill(8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 32'd2147483632);
    beat("t5", 1'b1, 1'b1, 2'b00);
    expect_d("t5", 2, -32'sd2147451406, -32'sd2147451406, -32'sd2147451406,
             -32'sd2147451406, 1'b1, 1);
    chk("t5_sat_d00", D_s[0][0], 32'h7FFF_FFFF);
    chk("t5_sat_d11", D_s[1][1], 32'h7FFF_FFFF);
    chk("t5_sat_ovf", ovf_s, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("t6_hold_valid", vout, 1'b1);
      chk("t6_hold_d01", D[0][1], -32'sd2147451406);
      chk("t6_hold_sat_d10", D_s[1][0], 32'h7FFF_FFFF);
    end
    handshake("t5");

    // 5b: after clamping, a later beat continues from the bound; ovf stays set
    fill(8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 32'd2147483632);
    beat("t5b1", 1'b1, 1'b0, 2'b00);
    fill(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'd1, 8'd1, 8'd1, 8'd1, 32'd0);
    beat("t5b2", 1'b0, 1'b1, 2'b00);
    expect_d("t5b", 2, -32'sd2147451408, -32'sd2147451408, -32'sd2147451408,
             -32'sd2147451408, 1'b1, 2);
    chk("t5b_sat_d00", D_s[0][0], 32'd2147483645);
    chk("t5b_sat_ovf", ovf_s, 1'b1);
    handshake("t5b");

    // 6: first_i inside a group restarts it from the new C
    fill(8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 32'd10);
    beat("t6a", 1'b1, 1'b0, 2'b00);
    chk("t6_no_err_on_open", perr, 1'b0);
    C = {4{32'd100}};
    beat("t6b", 1'b1, 1'b0, 2'b00);
    chk("t6_err_pulse", perr, 1'b1);
    beat("t6c", 1'b0, 1'b1, 2'b00);
    chk("t6_err_clear", perr, 1'b0);
    expect_d("t6", 2, 32'd102, 32'd102, 32'd102, 32'd102, 1'b0, 2);
    handshake("t6");

    // 7: async reset mid-group, then a fresh group
    fill(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 32'd50);
    beat("t7a", 1'b1, 1'b0, 2'b00);
    rst = 1'b1; #2;
    chk("t7_rst_d", D[0][0] | D[0][1] | D[1][0] | D[1][1], 32'd0);
    chk("t7_rst_cnt", cnt, 32'd0);
    chk("t7_rst_valid", vout, 1'b0);
    chk("t7_rst_ovf", ovf, 1'b0);
    @(posedge clk); #1; rst = 1'b0;
    chk("t7_ready_after_rst", rdy, 1'b1);
    C = '0;
    beat("t7b", 1'b1, 1'b1, 2'b00);
    expect_d("t7", 2, 32'd19, 32'd22, 32'd43, 32'd50, 1'b0, 1);
    handshake("t7");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matmul_kstream_accumulator.md
Name: matmul_kstream_accumulator

Overview:
Sequential successor to the single-shot matrix_multiplication_accumulation. It computes D = C + sum over beats of A_b x B_b. K arrives as a stream of KT-deep tiles under a valid/ready handshake, so the total K is unbounded and not fixed by hardware. Per group it supports three precision modes (8x8, mixed 8x4, packed 4x4), optional int32 saturation and a sticky overflow flag. It sits between the operand streamer and the result writeback.

Parameters:
- M, 2, rows of A/D
- N, 2, columns of B/D
- KT, 2, K elements per beat (P-bit lanes)
- P, 8, operand lane width; must be 8
- PIPE, 1, product register stages (0 or 1)
- SAT, 0, 1 = clamp accumulator to int32; 0 = wrap modulo 2^32
- CNT_W, 16, beat counter width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- A_i  in  [M][KT][P] signed  A tile
- B_i  in  [KT][N][P] signed  B tile
- C_i  in  [M][N][32] signed  initial accumulator, sampled on first beat
- mode_i  in  2  00 int8 x int8; 01 int8 x int4 (B low nibble); 10 packed int4 x int4; 11 reserved, treated as 00
- first_i  in  1  beat opens a group
- last_i  in  1  beat closes a group
- valid_in  in  1  beat valid
- ready_in  out  1  block accepts beat
- D_o  out  [M][N][32] signed  result
- valid_out  out  1  D_o valid
- ready_out  in  1  consumer accepts D_o
- ovf_o  out  1  sticky per group; valid with valid_out
- protocol_err_o  out  1  one-cycle pulse
- beat_cnt_o  out  CNT_W  beats in current/last group; saturates at all-ones

Behaviour:
- Transfer: a beat transfers when valid_in & ready_in is high at a rising edge.
- States and ready_in:
  - IDLE: ready_in = 1.
  - ACCUM: ready_in = 1.
  - DRAIN: ready_in = 0.
  - OUT: ready_in = 0.
- Transitions:
  - IDLE: any accepted beat starts a group (first_i is treated as 1). The beat loads the accumulator from C_i, latches mode_i, clears ovf, and sets beat_cnt = 1.
  - The first beat then goes to ACCUM, or to DRAIN if last_i = 1.
  - ACCUM with first_i = 0: the beat adds and increments the count. last_i = 1 goes to DRAIN.
  - ACCUM with first_i = 1: restarts the group (reload C_i, relatch mode, clear ovf, count = 1) and pulses protocol_err_o.
  - DRAIN: waits until the pipeline is empty, then goes to OUT.
  - OUT: holds valid_out = 1 with D_o and ovf_o stable. A valid_out & ready_out handshake goes to IDLE.
- Latency: valid_out rises 1 + PIPE cycles after the edge that accepted the last beat. ready_in rises the cycle after the output handshake. There is no overlap of groups.
- mode_i is ignored on non-first beats; the latched mode holds for the whole group.
- Per-beat lane product, per D[i][j] and per k:
  - 00: A * B, both 8-bit signed.
  - 01: A (8-bit signed) * sign-extended B[3:0]; B[7:4] is ignored.
  - 10: A[7:4]*B[7:4] + A[3:0]*B[3:0], all 4-bit signed. The high nibble is the even k, so the effective K per beat is 2*KT.
- Partial sum: summed exactly at 32 + clog2(2*KT) bits.
- Accumulate: the partial sum is added to the sign-extended accumulator at full width.
  - If the result is outside [-2^31, 2^31-1], set ovf (sticky).
  - SAT = 1: clamp to the bound, and later beats continue from the clamped value.
  - SAT = 0: truncate to 32 bits (wrap).
- Reset (async, at any time, including mid-group or in OUT):
  - state IDLE, ready_in = 1 after reset release
  - valid_out, protocol_err_o, ovf_o = 0
  - D_o = 0, beat_cnt_o = 0
  - pipeline valid bits cleared; in-flight beats are discarded.
- Beat count: beat_cnt_o saturates at 2^CNT_W - 1 with no wrap.

Decomposition:
- matmul_pkg holds:
  - ACC_W = 32
  - typedef prec_mode_e {PREC_8x8, PREC_8x4, PREC_4x4}
  - typedef kacc_state_e {IDLE, ACCUM, DRAIN, OUT}
  - functions sat_add32 and nibble sign-extend
- Sub-module mixed_precision_dot: combinational KT-lane dot product per output element, with mode select. It is instantiated M*N times. The top module holds the FSM, pipeline register, accumulators and counter.

Test Plan:
1. Mode 00, single beat (first = last = 1), A = [[1,2],[3,4]], B = [[5,6],[7,8]], C = 0 -> D = [[19,22],[43,50]]; valid_out 2 cycles after accept (PIPE = 1), ovf_o = 0, beat_cnt_o = 1.
2. Mode 00, three beats, A = I, B = all 1, C = all 10 -> D = all 13, beat_cnt_o = 3; ready_in = 0 from the last accept until the output handshake.
3. Mode 10, single beat, A = all 8'hF1 (-1, 1), B = all 8'h23 (2, 3), C = 0 -> D = all 2; mode 00 on the same data gives -15*35*2 = -1050.
4. Mode 01, single beat, A = all -128, B = all 8'h78 (low nibble -8) -> D = all 2048, proving B[7:4] is ignored.
5. C = all 2147483632, A = B = all 127, single beat:
   - SAT = 1 -> D = all 2147483647, ovf_o = 1.
   - SAT = 0 -> D = all -2147451406, ovf_o = 1.
6. Control and reset:
   - ready_out held 0 for 5 cycles -> D_o and valid_out stable.
   - first_i = 1 in ACCUM -> protocol_err_o pulses once and C is reloaded.
   - rst_i pulsed mid-group -> all outputs 0; the next beat with C = 0 computes fresh.
